// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, lock-FSM state type and a saturating counter helper,
// shared by the VGA timing generator and the receive-side sync decoder.
package vga_timing_pkg;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} sync_state_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// One-flop edge detector for an active-low VGA control line; the flop idles high.
module vga_edge_det (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q,
    output logic fall,
    output logic rise
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

    assign fall = q & ~d;
    assign rise = ~q & d;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing monitor: recovers coordinates and display enable, measures timing
// and reports lock. Optional frame/error counters are enabled by VGA_SYNC_DECODER_STATS_EN.
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        clr,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        rdn_in,
    output logic        de_out,
    output logic [8:0]  row_out,
    output logic [9:0]  col_out,
    output logic        locked,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
`ifdef VGA_SYNC_DECODER_STATS_EN
    output logic        err_pulse,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
`else
    output logic        err_pulse
`endif
);

    import vga_timing_pkg::*;

    localparam logic [10:0] LINE_TOTAL  = 11'(H_TOTAL);
    localparam logic [9:0]  FRAME_TOTAL = 10'(V_TOTAL);
    localparam logic [9:0]  COL_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  ROWS        = 10'(V_ACTIVE);
    localparam logic [8:0]  ROW_LAST    = 9'(V_ACTIVE - 1);
    localparam logic [3:0]  LOCK_N      = 4'(LOCK_FRAMES);

    logic hs_d, vs_d, rdn_d;
    logic hs_fall, vs_fall, de_rise;
    logic hs_rise, vs_rise, run_end;
    logic unused_edge;

    vga_edge_det u_hs_det (
        .clk  (vga_clk),
        .clr  (clr),
        .d    (hs_in),
        .q    (hs_d),
        .fall (hs_fall),
        .rise (hs_rise)
    );

    vga_edge_det u_vs_det (
        .clk  (vga_clk),
        .clr  (clr),
        .d    (vs_in),
        .q    (vs_d),
        .fall (vs_fall),
        .rise (vs_rise)
    );

    vga_edge_det u_rdn_det (
        .clk  (vga_clk),
        .clr  (clr),
        .d    (rdn_in),
        .q    (rdn_d),
        .fall (de_rise),
        .rise (run_end)
    );

    assign unused_edge = ^{hs_d, vs_d, rdn_d, hs_rise, vs_rise};

    logic [9:0]  pix_cnt;
    logic [9:0]  ln_cnt;
    logic [9:0]  act_lines;
    logic        first_hs;
    logic        bad_q;
    logic [3:0]  good_cnt;
    sync_state_t state;

    logic [10:0] line_len_new;
    logic        line_bad, col_bad, vs_bad, viol, timeout, err_next;

    always_comb begin
        line_len_new = {1'b0, pix_cnt} + 11'd1;
        line_bad     = hs_fall && !first_hs && (line_len_new != LINE_TOTAL);
        col_bad      = run_end && (col_out != COL_LAST);
        vs_bad       = vs_fall && ((ln_cnt != FRAME_TOTAL) || (act_lines != ROWS));
        viol         = line_bad || col_bad || vs_bad;
        // Fires only on the step into saturation, so a stuck hs gives one event.
        timeout      = !hs_fall && (pix_cnt == CNT_MAX - 10'd1);
        // Violations are not reported while searching: partial frames are expected there.
        err_next     = timeout || (viol && (state != SEARCH));
    end

    always_ff @(posedge vga_clk) begin
        if (clr) begin
            pix_cnt     <= '0;
            ln_cnt      <= '0;
            act_lines   <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            first_hs    <= 1'b1;
            de_out      <= 1'b0;
            col_out     <= '0;
            row_out     <= '0;
        end else begin
            de_out <= ~rdn_in;

            if (hs_fall) begin
                line_len <= line_len_new[9:0];
                pix_cnt  <= '0;
                first_hs <= 1'b0;
            end else begin
                pix_cnt <= sat_inc(pix_cnt);
                if (timeout) begin
                    first_hs <= 1'b1;
                end
            end

            if (vs_fall) begin
                frame_lines <= ln_cnt;
                ln_cnt      <= '0;
                act_lines   <= '0;
            end else begin
                if (hs_fall) begin
                    ln_cnt <= sat_inc(ln_cnt);
                end
                if (run_end) begin
                    act_lines <= sat_inc(act_lines);
                end
            end

            if (de_rise) begin
                col_out <= '0;
            end else if (!rdn_in) begin
                col_out <= sat_inc(col_out);
            end

            if (vs_fall) begin
                row_out <= '0;
            end else if (run_end) begin
                row_out <= (row_out == ROW_LAST) ? 9'd0 : row_out + 9'd1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (clr) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            bad_q     <= 1'b0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_next;
            if (timeout) begin
                state    <= SEARCH;
                good_cnt <= '0;
                bad_q    <= 1'b0;
                locked   <= 1'b0;
            end else if (vs_fall) begin
                bad_q <= 1'b0;
                case (state)
                    SEARCH: begin
                        state    <= CHECK;
                        good_cnt <= '0;
                    end
                    CHECK: begin
                        if (bad_q || viol) begin
                            good_cnt <= '0;
                        end else if (good_cnt + 4'd1 == LOCK_N) begin
                            good_cnt <= good_cnt + 4'd1;
                            state    <= LOCKED;
                            locked   <= 1'b1;
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (bad_q || viol) begin
                            state    <= CHECK;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end else if (viol) begin
                bad_q <= 1'b1;
            end
        end
    end

`ifdef VGA_SYNC_DECODER_STATS_EN
    always_ff @(posedge vga_clk) begin
        if (clr) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (vs_fall) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (err_next && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a scaled-down raster (100x30 clocks/lines)
// so each frame is short; frame-level vectors drive lock, error and measurement checks.
module tb_vga_sync_decoder;

    localparam int HT  = 100;
    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HSW = 12;
    localparam int VT  = 30;
    localparam int VA  = 20;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int HS_START = HA + HFP;
    localparam int VS_START = VA + VFP;

    logic       vga_clk = 1'b0;
    logic       clr     = 1'b1;
    logic       hs_in   = 1'b1;
    logic       vs_in   = 1'b1;
    logic       rdn_in  = 1'b1;
    logic       de_out;
    logic [8:0] row_out;
    logic [9:0] col_out;
    logic       locked;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       err_pulse;
`ifdef VGA_SYNC_DECODER_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    always #20 vga_clk = ~vga_clk;

    vga_sync_decoder #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .LOCK_FRAMES (2)
    ) dut (
        .vga_clk     (vga_clk),
        .clr         (clr),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .rdn_in      (rdn_in),
        .de_out      (de_out),
        .row_out     (row_out),
        .col_out     (col_out),
        .locked      (locked),
        .line_len    (line_len),
        .frame_lines (frame_lines),
`ifdef VGA_SYNC_DECODER_STATS_EN
        .err_pulse   (err_pulse),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`else
        .err_pulse   (err_pulse)
`endif
    );

    typedef struct {
        logic       de;
        logic       chk;
        logic [8:0] row;
        logic [9:0] col;
    } exp_t;

    typedef struct {
        int stretch_k;
        int hold;
        int rst_k;
        int rst_h;
        bit exp_locked;
        int exp_errs;
        int exp_len;
        int exp_lines;
    } frame_vec_t;

    exp_t       sb[$];
    frame_vec_t vecs[15];

    int   checks       = 0;
    int   errors       = 0;
    int   err_seen     = 0;
    int   err_base     = 0;
    int   vs_since_rst = 0;
    bit   coord_ok     = 1'b1;
    logic vs_prev      = 1'b1;

    always @(negedge vga_clk) begin
        if (err_pulse) err_seen++;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_cycle(input int h, input int v, input bit hold_hs, input bit rst);
        exp_t e;
        exp_t got;
        bit   vis;
        vis    = (h < HA) && (v < VA);
        hs_in  = hold_hs ? 1'b1 : !((h >= HS_START) && (h < HS_START + HSW));
        vs_in  = !((v >= VS_START) && (v < VS_START + VSW));
        rdn_in = !vis;
        clr    = rst;
        if (rst) begin
            coord_ok     = 1'b0;
            vs_since_rst = 0;
            err_base     = err_seen;
        end else if (vs_prev && !vs_in) begin
            coord_ok = 1'b1;
            vs_since_rst++;
        end
        vs_prev = vs_in;
        e.de  = vis && !rst;
        e.chk = vis && coord_ok && !rst;
        e.row = 9'(v);
        e.col = 10'(h);
        sb.push_back(e);
        @(posedge vga_clk);
        #1;
        got = sb.pop_front();
        check("de_out", de_out, got.de);
        if (got.chk) begin
            check("row_out", row_out, got.row);
            check("col_out", col_out, got.col);
        end
        if (rst) begin
            check("rst_locked", locked, 0);
            check("rst_line_len", line_len, 0);
            check("rst_frame_lines", frame_lines, 0);
            check("rst_err_pulse", err_pulse, 0);
            check("rst_row", row_out, 0);
            check("rst_col", col_out, 0);
            clr = 1'b0;
        end
    endtask

    // One frame measured from the cycle vs falls; optional stretched line, hs hold and reset.
    task automatic run_frame(input frame_vec_t fv);
        int n;
        int v;
        n = 0;
        for (int k = 0; k < VT; k++) begin
            v = (VS_START + k) % VT;
            for (int h = 0; h < HT; h++) begin
                drive_cycle(h, v, n < fv.hold, (k == fv.rst_k) && (h == fv.rst_h));
                n++;
            end
            if (k == fv.stretch_k) begin
                drive_cycle(HT, v, 1'b0, 1'b0);
                n++;
            end
        end
    endtask

    initial begin
        int errs_before;
        //            stretch hold   rst_k rst_h lock errs len  lines
        vecs[0]  = '{-1,      0,     -1,   0,    0,   0,   100, 22};
        vecs[1]  = '{-1,      0,     -1,   0,    0,   0,   100, 30};
        vecs[2]  = '{-1,      0,     -1,   0,    1,   0,   100, 30};
        vecs[3]  = '{5,       0,     -1,   0,    1,   1,   100, 30};
        vecs[4]  = '{-1,      0,     -1,   0,    0,   0,   100, 30};
        vecs[5]  = '{-1,      0,     -1,   0,    0,   0,   100, 30};
        vecs[6]  = '{-1,      0,     -1,   0,    1,   0,   100, 30};
        vecs[7]  = '{-1,      1100,  -1,   0,    0,   1,   100, 30};
        vecs[8]  = '{-1,      0,     -1,   0,    0,   0,   100, 19};
        vecs[9]  = '{-1,      0,     -1,   0,    0,   0,   100, 30};
        vecs[10] = '{-1,      0,     -1,   0,    1,   0,   100, 30};
        vecs[11] = '{-1,      0,     14,   10,   0,   0,   100, 0};
        vecs[12] = '{-1,      0,     -1,   0,    0,   0,   100, 16};
        vecs[13] = '{-1,      0,     -1,   0,    0,   0,   100, 30};
        vecs[14] = '{-1,      0,     -1,   0,    1,   0,   100, 30};

        clr = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        check("reset_de_out", de_out, 0);
        check("reset_row_out", row_out, 0);
        check("reset_col_out", col_out, 0);
        check("reset_locked", locked, 0);
        check("reset_line_len", line_len, 0);
        check("reset_frame_lines", frame_lines, 0);
        check("reset_err_pulse", err_pulse, 0);
        clr      = 1'b0;
        err_base = err_seen;

        for (int v = 0; v < VS_START; v++) begin
            for (int h = 0; h < HT; h++) begin
                drive_cycle(h, v, 1'b0, 1'b0);
            end
        end

        for (int i = 0; i < 15; i++) begin
            errs_before = err_seen;
            run_frame(vecs[i]);
            check($sformatf("frame%0d_locked", i), locked, vecs[i].exp_locked);
            check($sformatf("frame%0d_err_pulses", i), err_seen - errs_before, vecs[i].exp_errs);
            check($sformatf("frame%0d_line_len", i), line_len, vecs[i].exp_len);
            check($sformatf("frame%0d_frame_lines", i), frame_lines, vecs[i].exp_lines);
`ifdef VGA_SYNC_DECODER_STATS_EN
            check($sformatf("frame%0d_frame_cnt", i), frame_cnt, vs_since_rst);
            check($sformatf("frame%0d_err_cnt", i), err_cnt, err_seen - err_base);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
